// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares one dual-port Block_RAM between the AHB BRAM
// interface (fixed priority) and a secondary loader/DMA requester.
// Optional feature macro: BRAM_ARB_ANTISTARVE_EN. When it is defined, a
// starvation counter forces a one-cycle loader slot and raises ahb_stall.
// When it is undefined, ahb_stall is tied low and AHB has strict priority.
module bram_port_arbiter #(
  parameter int AW           = 14,
  parameter int STARVE_LIMIT = 16
) (
  input  logic          clk,
  input  logic          RST,
  input  logic [AW-1:0] a_wraddr,
  input  logic [3:0]    a_write,
  input  logic [31:0]   a_wdata,
  input  logic [AW-1:0] a_rdaddr,
  input  logic          a_rden,
  output logic [31:0]   a_rdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [31:0]   l_wdata,
  input  logic [3:0]    l_be,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [31:0]   l_rdata,
  output logic [AW-1:0] ram_addra,
  output logic [3:0]    ram_wea,
  output logic [31:0]   ram_dina,
  output logic [AW-1:0] ram_addrb,
  input  logic [31:0]   ram_doutb,
  output logic          ahb_stall
);

  typedef enum logic {IDLE, RD_DATA} state_t;

  state_t state_reg;
  state_t state_next;
  logic   stall_act;
  logic   a_wr_act;
  logic   a_rd_act;
  logic   gnt;

`ifdef BRAM_ARB_ANTISTARVE_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_cnt_reg;
  logic          stall_reg;

  // Count loader wait cycles; the cycle after the count reaches LIMIT-1 is
  // a forced loader slot that lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (RST) begin
      starve_cnt_reg <= '0;
      stall_reg      <= 1'b0;
    end else begin
      stall_reg <= 1'b0;
      if (stall_reg || gnt || !l_req) begin
        starve_cnt_reg <= '0;
      end else begin
        if (starve_cnt_reg != CW'(STARVE_LIMIT))
          starve_cnt_reg <= starve_cnt_reg + CW'(1);
        if (starve_cnt_reg == CW'(STARVE_LIMIT - 1))
          stall_reg <= 1'b1;
      end
    end
  end

  assign stall_act = stall_reg;
`else
  logic unused_cfg;
  assign unused_cfg = ^STARVE_LIMIT;
  assign stall_act  = 1'b0;
`endif

  assign ahb_stall = stall_act;

  // During a forced slot the AHB side is ignored on both ports.
  assign a_wr_act = (a_write != 4'h0) && !stall_act;
  assign a_rd_act = a_rden && !stall_act;

  // State register.
  always_ff @(posedge clk) begin
    if (RST) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Grant decision and next state: one loader transaction in flight at a time.
  always_comb begin
    state_next = state_reg;
    gnt        = 1'b0;
    case (state_reg)
      IDLE: begin
        // AHB using both ports blocks the loader whatever direction it wants.
        if (!RST && l_req && !(a_wr_act && a_rd_act)) begin
          if (l_we) begin
            if (!a_wr_act) gnt = 1'b1;
          end else if (!a_rd_act) begin
            gnt        = 1'b1;
            state_next = RD_DATA;
          end
        end
      end
      RD_DATA: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Port muxes: AHB addresses pass through unless the loader owns the port.
  always_comb begin
    ram_addra = a_wraddr;
    ram_wea   = 4'h0;
    ram_dina  = a_wdata;
    ram_addrb = a_rdaddr;
    if (!RST) begin
      if (a_wr_act) begin
        ram_wea = a_write;
      end else if (gnt && l_we) begin
        ram_addra = l_addr;
        ram_wea   = l_be;
        ram_dina  = l_wdata;
      end
    end
    if (gnt && !l_we) ram_addrb = l_addr;
  end

  // Capture loader read data the cycle after the RAM presents it.
  always_ff @(posedge clk) begin
    if (RST) begin
      l_rvalid <= 1'b0;
      l_rdata  <= 32'h0;
    end else begin
      l_rvalid <= (state_reg == RD_DATA);
      if (state_reg == RD_DATA) l_rdata <= ram_doutb;
    end
  end

  assign l_gnt   = gnt;
  assign a_rdata = ram_doutb;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Testbench for bram_port_arbiter: directed vectors, scoreboard queues for
// RAM writes and loader read data, behavioural dual-port RAM model.
module tb_bram_port_arbiter;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          RST;
  logic [AW-1:0] a_wraddr, a_rdaddr, l_addr;
  logic [3:0]    a_write, l_be;
  logic [31:0]   a_wdata, l_wdata;
  logic          a_rden, l_req, l_we;
  logic [31:0]   a_rdata, l_rdata, ram_dina, ram_doutb;
  logic          l_gnt, l_rvalid, ahb_stall;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [3:0]    ram_wea;

  int total = 0;
  int bad   = 0;

  logic [31:0]        rd_q[$];
  logic [AW+36-1:0]   wr_q[$];
  logic [31:0]        mem [0:(1<<AW)-1];

  bram_port_arbiter #(.AW(AW), .STARVE_LIMIT(16)) dut (
    .clk(clk), .RST(RST),
    .a_wraddr(a_wraddr), .a_write(a_write), .a_wdata(a_wdata),
    .a_rdaddr(a_rdaddr), .a_rden(a_rden), .a_rdata(a_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_be(l_be),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .ram_addra(ram_addra), .ram_wea(ram_wea), .ram_dina(ram_dina),
    .ram_addrb(ram_addrb), .ram_doutb(ram_doutb), .ahb_stall(ahb_stall)
  );

  always #5 clk = ~clk;

  // RAM model: byte writes on port A, registered read-old-data on port B.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (ram_wea[b]) mem[ram_addra][b*8 +: 8] <= ram_dina[b*8 +: 8];
    ram_doutb <= mem[ram_addrb];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 10; i++) begin
      if (rd_q.size() == 0) break;
      @(posedge clk);
    end
    check("read_drain", 64'(rd_q.size()), 64'd0);
    #1;
  endtask

  task automatic push_wr(input logic [AW-1:0] ad, input logic [3:0] be, input logic [31:0] d);
    wr_q.push_back({ad, be, d});
  endtask

  // Monitor: every RAM write and every loader read return is popped and compared.
  always @(negedge clk) begin
    if (l_rvalid) begin
      if (rd_q.size() == 0) check("rvalid_unexpected", 64'd1, 64'd0);
      else check("l_rdata", 64'(l_rdata), 64'(rd_q.pop_front()));
    end
    if (ram_wea != 4'h0) begin
      if (wr_q.size() == 0) check("ram_write_unexpected", 64'(ram_wea), 64'd0);
      else check("ram_write", 64'({ram_addra, ram_wea, ram_dina}), 64'(wr_q.pop_front()));
    end
  end

  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = 32'h0;
    RST = 1'b1;
    a_wraddr = '0; a_write = 4'hF; a_wdata = 32'h0; a_rdaddr = '0; a_rden = 1'b0;
    l_req = 1'b1; l_we = 1'b1; l_addr = '0; l_wdata = 32'h0; l_be = 4'hF;
    repeat (3) step();
    @(negedge clk);
    check("rst_l_gnt", 64'(l_gnt), 64'd0);
    check("rst_ram_wea", 64'(ram_wea), 64'd0);
    check("rst_ahb_stall", 64'(ahb_stall), 64'd0);
    check("rst_l_rvalid", 64'(l_rvalid), 64'd0);
    check("rst_l_rdata", 64'(l_rdata), 64'd0);
    step();
    RST = 1'b0; l_req = 1'b0; a_write = 4'h0;

    // Test 1: loader write then read of address 5 with AHB idle.
    step();
    l_req = 1'b1; l_we = 1'b1; l_addr = 14'd5; l_wdata = 32'hDEADBEEF; l_be = 4'hF;
    push_wr(14'd5, 4'hF, 32'hDEADBEEF);
    @(negedge clk);
    check("t1_wr_gnt", 64'(l_gnt), 64'd1);
    check("t1_wr_addra", 64'(ram_addra), 64'd5);
    step();
    l_we = 1'b0;
    rd_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    check("t1_rd_gnt", 64'(l_gnt), 64'd1);
    check("t1_rd_addrb", 64'(ram_addrb), 64'd5);
    step();
    l_req = 1'b0;
    drain();

    // Test 2: AHB byte writes hold off a pending loader write for 3 cycles.
    push_wr(14'd10, 4'h1, 32'h000000A0);
    push_wr(14'd11, 4'h1, 32'h000000A1);
    push_wr(14'd12, 4'h1, 32'h000000A2);
    push_wr(14'd20, 4'h3, 32'hCAFEF00D);
    for (int k = 0; k < 3; k++) begin
      step();
      a_write = 4'h1; a_wraddr = 14'(10 + k); a_wdata = 32'(32'hA0 + k);
      l_req = 1'b1; l_we = 1'b1; l_addr = 14'd20; l_wdata = 32'hCAFEF00D; l_be = 4'h3;
      @(negedge clk);
      check("t2_blocked_gnt", 64'(l_gnt), 64'd0);
    end
    step();
    a_write = 4'h0;
    @(negedge clk);
    check("t2_cycle4_gnt", 64'(l_gnt), 64'd1);
    step();
    l_we = 1'b0; l_addr = 14'd20;
    rd_q.push_back(32'h0000F00D);
    @(negedge clk);
    check("t2_rd_gnt", 64'(l_gnt), 64'd1);
    step();
    l_req = 1'b0;
    drain();

    // Test 3: AHB read and loader write share the cycle on separate ports.
    step();
    a_rden = 1'b1; a_rdaddr = 14'd5;
    l_req = 1'b1; l_we = 1'b1; l_addr = 14'd7; l_wdata = 32'h12345678; l_be = 4'hF;
    push_wr(14'd7, 4'hF, 32'h12345678);
    @(negedge clk);
    check("t3_gnt", 64'(l_gnt), 64'd1);
    check("t3_addrb", 64'(ram_addrb), 64'd5);
    step();
    l_req = 1'b0;
    @(negedge clk);
    check("t3_a_rdata", 64'(a_rdata), 64'hDEADBEEF);
    // AHB using both ports: loader read and write both wait; then withdraws.
    step();
    a_write = 4'h2; a_wraddr = 14'd30; a_wdata = 32'h0000BB00;
    push_wr(14'd30, 4'h2, 32'h0000BB00);
    l_req = 1'b1; l_we = 1'b0; l_addr = 14'd7;
    @(negedge clk);
    check("both_busy_rd_gnt", 64'(l_gnt), 64'd0);
    step();
    a_write = 4'h0;
    push_wr(14'd31, 4'h0, 32'h0);
    l_we = 1'b1; l_be = 4'h0; l_addr = 14'd31; l_wdata = 32'h0;
    a_write = 4'h4; a_wraddr = 14'd32; a_wdata = 32'h00CC0000;
    void'(wr_q.pop_back());
    push_wr(14'd32, 4'h4, 32'h00CC0000);
    @(negedge clk);
    check("both_busy_wr_gnt", 64'(l_gnt), 64'd0);
    // Loader read beside an AHB write.
    step();
    a_rden = 1'b0; a_write = 4'hF; a_wraddr = 14'd40; a_wdata = 32'h55AA55AA;
    push_wr(14'd40, 4'hF, 32'h55AA55AA);
    l_we = 1'b0; l_addr = 14'd7;
    rd_q.push_back(32'h12345678);
    @(negedge clk);
    check("rd_beside_ahb_wr_gnt", 64'(l_gnt), 64'd1);
    check("rd_beside_ahb_wr_addrb", 64'(ram_addrb), 64'd7);
    step();
    a_write = 4'h0; l_req = 1'b0;
    drain();

    // Test 4: reset while the read is in its data cycle drops it.
    step();
    l_req = 1'b1; l_we = 1'b0; l_addr = 14'd5;
    @(negedge clk);
    check("t4_gnt", 64'(l_gnt), 64'd1);
    step();
    l_req = 1'b0; RST = 1'b1;
    step();
    RST = 1'b0;
    @(negedge clk);
    check("t4_rvalid", 64'(l_rvalid), 64'd0);
    check("t4_rdata", 64'(l_rdata), 64'd0);
    step();
    l_req = 1'b1;
    rd_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    check("t4_rereq_gnt", 64'(l_gnt), 64'd1);
    step();
    l_req = 1'b0;
    drain();

    // Tests 5/6: AHB reads continuously while a loader read waits.
    step();
    a_rden = 1'b1; a_rdaddr = 14'd0;
    l_req = 1'b1; l_we = 1'b0; l_addr = 14'd5;
`ifdef BRAM_ARB_ANTISTARVE_EN
    begin
      int gnt_cycle;
      gnt_cycle = 0;
      rd_q.push_back(32'hDEADBEEF);
      for (int w = 1; w <= 40; w++) begin
        @(negedge clk);
        if (l_gnt) begin
          gnt_cycle = w;
          check("t5_stall_at_gnt", 64'(ahb_stall), 64'd1);
          break;
        end
        check("t5_no_early_stall", 64'(ahb_stall), 64'd0);
        @(posedge clk); #1;
      end
      check("t5_gnt_cycle", 64'(gnt_cycle), 64'd17);
      step();
      l_req = 1'b0; a_rden = 1'b0;
      @(negedge clk);
      check("t5_stall_one_cycle", 64'(ahb_stall), 64'd0);
      drain();
    end
`else
    begin
      int hits;
      hits = 0;
      for (int w = 0; w < 100; w++) begin
        @(negedge clk);
        if (l_gnt || ahb_stall) hits++;
      end
      check("t6_starve_no_gnt_no_stall", 64'(hits), 64'd0);
      step();
      l_req = 1'b0; a_rden = 1'b0;
    end
`endif

    repeat (3) step();
    check("wr_queue_empty", 64'(wr_q.size()), 64'd0);
    check("rd_queue_empty", 64'(rd_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
